uart_rx_ctrl: RTL and testbench

//   UART receive controller: the receive end of the UART serial link. Detects the start
//   bit, oversamples each bit (x prescale), majority-votes and deserialises 8 data bits
//   (LSB first), checks optional parity and the stop bit, and pulses data_valid for a

---
 rtl/uart_rx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit detection, 3-sample majority voting per bit,
// LSB-first deserialisation, optional parity and stop-bit checking.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [5:0]            edge_cnt;
  logic [5:0]            ps_q;
  logic                  pe_q;
  logic                  pt_q;
  logic [BCW-1:0]        bit_cnt;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] shift;

  logic [5:0] half;
  logic       bit_val;
  logic       bit_end;
  logic       vote_pt;
  logic       stop_pt;

  assign half    = {1'b0, ps_q[5:1]};
  assign bit_val = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign bit_end = (edge_cnt == ps_q - 6'd1);
  assign vote_pt = (edge_cnt == half + 6'd2);
  // Stop-bit verdict is registered one edge early so data_valid is high on the bit's last clk.
  assign stop_pt = (edge_cnt == ps_q - 6'd2);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      ps_q       <= 6'd16;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      bit_cnt    <= '0;
      samp       <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
        if (edge_cnt == half - 6'd1) samp[0] <= rx_in;
        if (edge_cnt == half)        samp[1] <= rx_in;
        if (edge_cnt == half + 6'd1) samp[2] <= rx_in;
      end

      case (state)
        IDLE: begin
          edge_cnt <= 6'd0;
          if (!rx_in) begin
            state    <= START;
            edge_cnt <= 6'd1;
            ps_q     <= prescale;
            pe_q     <= par_en;
            pt_q     <= par_typ;
            par_err  <= 1'b0;
            stp_err  <= 1'b0;
          end
        end
        START: begin
          if (vote_pt && bit_val) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= {bit_val, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BCW'(DATA_WIDTH - 1))
              state <= pe_q ? PARITY : STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_err <= (bit_val != (^shift ^ pt_q));
            state   <= STOP;
          end
        end
        STOP: begin
          if (stop_pt) begin
            stp_err <= ~bit_val;
            if (bit_val && !par_err) begin
              data_out   <= shift;
              data_valid <= 1'b1;
            end
          end
          if (bit_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives bit-accurate serial frames and checks
// received bytes, error flags and valid pulses against hand-computed values.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [7:0] rxq[$];

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .data_out(data_out),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      rxq.push_back(data_out);
    end
  end

  task automatic drive_bit(input logic val, input int ps, input logic inv);
    for (int i = 0; i < ps; i++) begin
      @(negedge clk);
      rx_in = (inv && i == ps / 2) ? ~val : val;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // pbit: parity bit value to put on the wire (used only when pe=1)
  task automatic send_frame(input logic [7:0] d, input int ps, input logic pe,
                            input logic pbit, input logic stopv, input logic inv);
    drive_bit(1'b0, ps, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(d[b], ps, inv);
    if (pe) drive_bit(pbit, ps, 1'b0);
    drive_bit(stopv, ps, 1'b0);
  endtask

  task automatic clear_mon();
    pulses = 0;
    rxq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    total++; if (par_err !== 1'b0) begin bad++; $display("FAIL reset_par_err got=%b exp=0", par_err); end
    total++; if (stp_err !== 1'b0) begin bad++; $display("FAIL reset_stp_err got=%b exp=0", stp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    clear_mon();
    prescale = 6'd8; par_en = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    total++; if (pulses !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    total++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b exp=00", par_err, stp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
  endtask

  task automatic test_parity();
    clear_mon();
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    total++; if (pulses !== 1) begin bad++; $display("FAIL even_ok_pulses got=%0d exp=1", pulses); end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL even_ok_data got=%h exp=3c", data_out); end
    total++; if (par_err !== 1'b0) begin bad++; $display("FAIL even_ok_par_err got=%b exp=0", par_err); end
    clear_mon();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    total++; if (par_err !== 1'b1) begin bad++; $display("FAIL even_bad_par_err got=%b exp=1", par_err); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL even_bad_pulses got=%0d exp=0", pulses); end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL even_bad_data got=%h exp=3c", data_out); end
  endtask

  task automatic test_odd_parity();
    clear_mon();
    prescale = 6'd32; par_en = 1'b1; par_typ = 1'b1;
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    total++; if (pulses !== 1) begin bad++; $display("FAIL odd_pulses got=%0d exp=1", pulses); end
    total++; if (data_out !== 8'h01) begin bad++; $display("FAIL odd_data got=%h exp=01", data_out); end
    total++; if (par_err !== 1'b0) begin bad++; $display("FAIL odd_par_err got=%b exp=0", par_err); end
  endtask

  task automatic test_stop_err();
    clear_mon();
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    total++; if (stp_err !== 1'b1) begin bad++; $display("FAIL stop_stp_err got=%b exp=1", stp_err); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL stop_pulses got=%0d exp=0", pulses); end
    total++; if (data_out !== 8'h01) begin bad++; $display("FAIL stop_data_kept got=%h exp=01", data_out); end
    clear_mon();
    fork
      send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        total++; if (stp_err !== 1'b0) begin bad++; $display("FAIL stop_clear_at_start got=%b exp=0", stp_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy_in_frame got=%b exp=1", busy); end
      end
    join
    idle(10);
    total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL stop_next_data got=%h exp=0f", data_out); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stop_next_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_glitch();
    clear_mon();
    prescale = 6'd8;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    idle(10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_drop got=%b exp=0", busy); end
    total++; if (pulses !== 0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
      bad++; $display("FAIL glitch_quiet got pulses=%0d flags=%b%b exp 0/00", pulses, par_err, stp_err);
    end
    clear_mon();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(10);
    total++; if (pulses !== 1 || data_out !== 8'hC3) begin
      bad++; $display("FAIL majority got pulses=%0d data=%h exp 1/c3", pulses, data_out);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    prescale = 6'd16; par_en = 1'b0;
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    if (rxq.size() == 2) begin
      total++; if (rxq[0] !== 8'h12) begin bad++; $display("FAIL b2b_first got=%h exp=12", rxq[0]); end
      total++; if (rxq[1] !== 8'h34) begin bad++; $display("FAIL b2b_second got=%h exp=34", rxq[1]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    prescale = 6'd8;
    drive_bit(1'b0, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    drive_bit(1'b1, 4, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", data_out); end
    total++; if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
      bad++; $display("FAIL midrst_flags got=%b%b%b exp=000", data_valid, par_err, stp_err);
    end
    rst = 1'b1;
    idle(100);
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_odd_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
